// File: rtl/gbe_app_pktgen_if.sv
// Application TX byte interface between the traffic generator and the UDP GbE core.
// The generator drives the payload bytes and the destination; the core returns its FIFO status.
interface gbe_app_pktgen_if;
  logic [7:0]  app_tx_data;
  logic        app_tx_dvld;
  logic        app_tx_eof;
  logic [31:0] app_tx_destip;
  logic [15:0] app_tx_destport;
  logic        app_tx_afull;
  logic        app_tx_overflow;

  modport master (
    output app_tx_data, app_tx_dvld, app_tx_eof, app_tx_destip, app_tx_destport,
    input  app_tx_afull, app_tx_overflow
  );

  modport slave (
    input  app_tx_data, app_tx_dvld, app_tx_eof, app_tx_destip, app_tx_destport,
    output app_tx_afull, app_tx_overflow
  );
endinterface

// File: rtl/gbe_app_pktgen.sv
// UDP test-traffic generator: numbered payloads of configurable length and gap,
// paced by the core's almost-full flag. All outputs are registered.
module gbe_app_pktgen #(
  parameter int unsigned MIN_LEN = 4,
  parameter int unsigned MAX_LEN = 1472
) (
  input  logic                    app_clk,
  input  logic                    app_rst,
  input  logic                    cfg_enable,
  input  logic [15:0]             cfg_length,
  input  logic [15:0]             cfg_gap,
  input  logic [31:0]             cfg_count,
  input  logic [31:0]             cfg_destip,
  input  logic [15:0]             cfg_destport,
  gbe_app_pktgen_if.master        tx,
  output logic [31:0]             pkt_sent,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow_seen
);

  localparam logic [15:0] MinLen = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_len, w_len_d, r_gap, w_gap_d, r_gap_cnt, w_gap_cnt_d;
  logic [15:0] r_byte_idx, w_byte_idx_d, r_destport, w_destport_d;
  logic [31:0] r_count, w_count_d, r_seq, w_seq_d, r_pkt_sent, w_pkt_sent_d;
  logic [31:0] r_destip, w_destip_d;
  logic [7:0]  r_data, w_data_d;
  logic        r_dvld, w_dvld_d, r_eof, w_eof_d, r_busy, w_busy_d;
  logic        r_done, w_done_d, r_ovf, w_ovf_d;

  logic [15:0] w_eff_len;
  logic [7:0]  w_seq_byte, w_byte;
  logic [31:0] w_pkt_inc;
  logic        w_last;

  assign w_eff_len = (cfg_length < MinLen) ? MinLen :
                     (cfg_length > MaxLen) ? MaxLen : cfg_length;
  assign w_pkt_inc = r_pkt_sent + 32'd1;
  assign w_last    = (r_byte_idx == r_len - 16'd1);

  // Sequence number goes out big-endian in the first four bytes.
  always_comb begin
    unique case (r_byte_idx[1:0])
      2'd0:    w_seq_byte = r_seq[31:24];
      2'd1:    w_seq_byte = r_seq[23:16];
      2'd2:    w_seq_byte = r_seq[15:8];
      default: w_seq_byte = r_seq[7:0];
    endcase
  end
  assign w_byte = (r_byte_idx < 16'd4) ? w_seq_byte : r_byte_idx[7:0];

  always_comb begin
    w_state_d    = r_state;
    w_len_d      = r_len;
    w_gap_d      = r_gap;
    w_gap_cnt_d  = r_gap_cnt;
    w_byte_idx_d = r_byte_idx;
    w_count_d    = r_count;
    w_seq_d      = r_seq;
    w_pkt_sent_d = r_pkt_sent;
    w_destip_d   = r_destip;
    w_destport_d = r_destport;
    w_data_d     = 8'h00;
    w_dvld_d     = 1'b0;
    w_eof_d      = 1'b0;
    w_ovf_d      = r_ovf | (tx.app_tx_overflow & r_busy);
    case (r_state)
      StIdle: if (cfg_enable) w_state_d = StLoad;
      StLoad: begin
        w_len_d      = w_eff_len;
        w_gap_d      = cfg_gap;
        w_count_d    = cfg_count;
        w_destip_d   = cfg_destip;
        w_destport_d = cfg_destport;
        w_seq_d      = '0;
        w_byte_idx_d = '0;
        w_pkt_sent_d = '0;
        w_ovf_d      = 1'b0;
        w_state_d    = StSend;
      end
      StSend: begin
        if (!tx.app_tx_afull) begin
          w_data_d = w_byte;
          w_dvld_d = 1'b1;
          if (w_last) begin
            w_eof_d      = 1'b1;
            w_pkt_sent_d = w_pkt_inc;
            w_seq_d      = r_seq + 32'd1;
            w_byte_idx_d = '0;
            if ((r_count != '0) && (w_pkt_inc == r_count)) w_state_d = StDone;
            else if (!cfg_enable)                          w_state_d = StIdle;
            else if (r_gap == '0)                          w_state_d = StSend;
            else begin
              // Counter reaches zero on the last idle cycle, so SEND resumes on time.
              w_state_d   = StGap;
              w_gap_cnt_d = r_gap - 16'd1;
            end
          end else begin
            w_byte_idx_d = r_byte_idx + 16'd1;
          end
        end
      end
      StGap: begin
        if (!cfg_enable)            w_state_d = StIdle;
        else if (r_gap_cnt == '0)   w_state_d = StSend;
        else                        w_gap_cnt_d = r_gap_cnt - 16'd1;
      end
      StDone: if (!cfg_enable) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d == StLoad) || (w_state_d == StSend) || (w_state_d == StGap);
    w_done_d = (w_state_d == StDone);
  end

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_byte_idx <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_pkt_sent <= '0;
      r_destip   <= '0;
      r_destport <= '0;
      r_data     <= '0;
      r_dvld     <= 1'b0;
      r_eof      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_len      <= w_len_d;
      r_gap      <= w_gap_d;
      r_gap_cnt  <= w_gap_cnt_d;
      r_byte_idx <= w_byte_idx_d;
      r_count    <= w_count_d;
      r_seq      <= w_seq_d;
      r_pkt_sent <= w_pkt_sent_d;
      r_destip   <= w_destip_d;
      r_destport <= w_destport_d;
      r_data     <= w_data_d;
      r_dvld     <= w_dvld_d;
      r_eof      <= w_eof_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_ovf      <= w_ovf_d;
    end
  end

  assign tx.app_tx_data     = r_data;
  assign tx.app_tx_dvld     = r_dvld;
  assign tx.app_tx_eof      = r_eof;
  assign tx.app_tx_destip   = r_destip;
  assign tx.app_tx_destport = r_destport;
  assign pkt_sent           = r_pkt_sent;
  assign busy               = r_busy;
  assign done               = r_done;
  assign overflow_seen      = r_ovf;

endmodule

// File: tb/tb_gbe_app_pktgen.sv
// Bench for gbe_app_pktgen: table-driven runs, random backpressure runs against a payload
// model, and hand sequences for pause, stop, overflow and reset.
module tb_gbe_app_pktgen;

  logic        app_clk = 1'b0;
  logic        app_rst;
  logic        cfg_enable;
  logic [15:0] cfg_length, cfg_gap, cfg_destport;
  logic [31:0] cfg_count, cfg_destip;
  logic [31:0] pkt_sent;
  logic        busy, done, overflow_seen;

  gbe_app_pktgen_if bus ();

  gbe_app_pktgen dut (
    .app_clk       (app_clk),
    .app_rst       (app_rst),
    .cfg_enable    (cfg_enable),
    .cfg_length    (cfg_length),
    .cfg_gap       (cfg_gap),
    .cfg_count     (cfg_count),
    .cfg_destip    (cfg_destip),
    .cfg_destport  (cfg_destport),
    .tx            (bus),
    .pkt_sent      (pkt_sent),
    .busy          (busy),
    .done          (done),
    .overflow_seen (overflow_seen)
  );

  always #5 app_clk = ~app_clk;

  typedef struct {
    logic [15:0] len;
    logic [15:0] gap;
    logic [31:0] cnt;
    int unsigned exp_len;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc = 0;
  logic        man_afull = 1'b0;
  bit          rnd_afull = 1'b0;
  logic [7:0]  q_data[$];
  bit          q_eof[$];
  int          q_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge app_clk) cyc <= cyc + 1;

  // afull is applied 2 ns after each edge so hand sequences can set man_afull at +1 ns.
  initial begin
    bus.app_tx_afull = 1'b0;
    forever begin
      @(posedge app_clk);
      #2;
      bus.app_tx_afull = rnd_afull ? ($urandom_range(0, 3) == 0) : man_afull;
    end
  end

  always @(negedge app_clk) begin
    if (bus.app_tx_dvld) begin
      q_data.push_back(bus.app_tx_data);
      q_eof.push_back(bus.app_tx_eof);
      q_cyc.push_back(cyc);
    end
    if (bus.app_tx_eof) check("eof_with_dvld", 32'(bus.app_tx_dvld), 32'd1);
  end

  function automatic int unsigned clamp_len(input int unsigned l);
    if (l < 4) return 4;
    if (l > 1472) return 1472;
    return l;
  endfunction

  // Payload rule: sequence number big-endian, then the low byte of the byte index.
  function automatic logic [7:0] exp_byte(input int unsigned pkt, input int unsigned i);
    if (i < 4) return 8'((pkt >> (8 * (3 - i))) & 32'hff);
    return 8'(i & 32'hff);
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_eof.delete();
    q_cyc.delete();
  endtask

  task automatic check_stream(input string nm, input int unsigned eff, input int unsigned npkts);
    check({nm, " byte total"}, 32'(q_data.size()), 32'(npkts * eff));
    for (int unsigned p = 0; p < npkts; p++) begin
      int unsigned bad = 0;
      for (int unsigned i = 0; i < eff; i++) begin
        int unsigned idx = p * eff + i;
        if (idx >= q_data.size()) bad++;
        else begin
          if (q_data[idx] !== exp_byte(p, i)) bad++;
          if (q_eof[idx] != (i == eff - 1)) bad++;
        end
      end
      check($sformatf("%s pkt%0d bad bytes", nm, p), bad, 0);
    end
  endtask

  task automatic check_gaps(input string nm, input int unsigned eff, input int unsigned gap);
    int unsigned bad = 0;
    for (int j = 1; j < q_cyc.size(); j++) begin
      int unsigned want = ((j % eff) == 0) ? gap + 1 : 1;
      if (q_cyc[j] - q_cyc[j-1] != int'(want)) bad++;
    end
    check({nm, " spacing errors"}, bad, 0);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      @(negedge app_clk);
      #1;
      k++;
    end
    check($sformatf("reached %0d bytes", n), 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic run(input string nm, input logic [15:0] len, input logic [15:0] gap,
                     input logic [31:0] cnt, input int unsigned eff, input bit rnd,
                     input bit gchk);
    logic [31:0] ip;
    logic [15:0] port;
    int          k = 0;
    int          budget;
    ip = $urandom;
    port = 16'($urandom);
    budget = int'(cnt) * (int'(eff) + int'(gap) + 2) * 8 + 50;
    clear_q();
    cfg_length = len;
    cfg_gap = gap;
    cfg_count = cnt;
    cfg_destip = ip;
    cfg_destport = port;
    rnd_afull = rnd;
    @(posedge app_clk);
    #1 cfg_enable = 1'b1;
    if (rnd) begin
      // Configuration is latched by now; later changes must not matter.
      repeat (4) @(posedge app_clk);
      #1;
      cfg_length = 16'($urandom);
      cfg_gap = 16'($urandom_range(0, 7));
      cfg_count = cnt + 32'd3;
      cfg_destip = ~ip;
      cfg_destport = ~port;
    end
    while (!done && k < budget) begin
      @(negedge app_clk);
      k++;
    end
    check({nm, " done"}, 32'(done), 32'd1);
    check({nm, " pkt_sent"}, pkt_sent, cnt);
    check({nm, " busy"}, 32'(busy), 32'd0);
    check({nm, " destip"}, bus.app_tx_destip, ip);
    check({nm, " destport"}, 32'(bus.app_tx_destport), 32'(port));
    rnd_afull = 1'b0;
    @(negedge app_clk);
    #1;
    check_stream(nm, eff, cnt);
    if (gchk) check_gaps(nm, eff, gap);
    @(posedge app_clk);
    #1 cfg_enable = 1'b0;
    repeat (2) @(negedge app_clk);
    check({nm, " done cleared"}, 32'(done), 32'd0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{len: 16'd8,    gap: 16'd0, cnt: 32'd2, exp_len: 8};
    tbl[1] = '{len: 16'd2,    gap: 16'd0, cnt: 32'd1, exp_len: 4};
    tbl[2] = '{len: 16'd2000, gap: 16'd0, cnt: 32'd1, exp_len: 1472};
    tbl[3] = '{len: 16'd16,   gap: 16'd3, cnt: 32'd3, exp_len: 16};
    tbl[4] = '{len: 16'd5,    gap: 16'd1, cnt: 32'd2, exp_len: 5};
    tbl[5] = '{len: 16'd1472, gap: 16'd2, cnt: 32'd1, exp_len: 1472};
    tbl[6] = '{len: 16'd0,    gap: 16'd0, cnt: 32'd3, exp_len: 4};

    app_rst = 1'b1;
    cfg_enable = 1'b0;
    cfg_length = 16'd8;
    cfg_gap = 16'd0;
    cfg_count = 32'd1;
    cfg_destip = 32'h0a000001;
    cfg_destport = 16'd1234;
    bus.app_tx_overflow = 1'b0;
    repeat (3) @(posedge app_clk);
    @(negedge app_clk);
    check("reset dvld", 32'(bus.app_tx_dvld), 32'd0);
    check("reset eof", 32'(bus.app_tx_eof), 32'd0);
    check("reset pkt_sent", pkt_sent, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset destip", bus.app_tx_destip, 32'd0);
    @(posedge app_clk);
    #1 app_rst = 1'b0;

    for (int v = 0; v < 7; v++)
      run($sformatf("vec%0d", v), tbl[v].len, tbl[v].gap, tbl[v].cnt, tbl[v].exp_len, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      logic [15:0] l;
      logic [15:0] g;
      logic [31:0] c;
      l = (r == 2) ? 16'd1500 : 16'($urandom_range(0, 90));
      g = 16'($urandom_range(0, 4));
      c = 32'($urandom_range(1, 4));
      run($sformatf("rand%0d", r), l, g, c, clamp_len(int'(l)), 1'b1, 1'b0);
    end

    // Backpressure pause: afull high for 5 cycles while byte 20 is on the bus.
    begin
      int unsigned bad = 0;
      clear_q();
      cfg_length = 16'd64;
      cfg_gap = 16'd0;
      cfg_count = 32'd1;
      @(posedge app_clk);
      #1 cfg_enable = 1'b1;
      wait_bytes(20, 200);
      @(posedge app_clk);
      #1 man_afull = 1'b1;
      repeat (5) @(posedge app_clk);
      #1 man_afull = 1'b0;
      wait_bytes(64, 300);
      repeat (2) @(negedge app_clk);
      #1;
      check_stream("pause", 64, 1);
      for (int j = 1; j < q_cyc.size(); j++)
        if (q_cyc[j] - q_cyc[j-1] != ((j == 21) ? 6 : 1)) bad++;
      check("pause spacing errors", bad, 0);
      check("pause done", 32'(done), 32'd1);
      @(posedge app_clk);
      #1 cfg_enable = 1'b0;
      repeat (2) @(posedge app_clk);
    end

    // Stop mid-packet: the packet completes, then no more bytes.
    begin
      int k = 0;
      clear_q();
      cfg_length = 16'd64;
      cfg_count = 32'd0;
      @(posedge app_clk);
      #1 cfg_enable = 1'b1;
      wait_bytes(10, 200);
      @(posedge app_clk);
      #1 cfg_enable = 1'b0;
      while (busy && k < 200) begin
        @(negedge app_clk);
        k++;
      end
      repeat (10) @(negedge app_clk);
      #1;
      check_stream("stop", 64, 1);
      check("stop busy", 32'(busy), 32'd0);
      check("stop done", 32'(done), 32'd0);
      check("stop pkt_sent", pkt_sent, 32'd1);
    end

    // Overflow stickiness, then reset mid-packet, then a clean restart.
    clear_q();
    cfg_length = 16'd8;
    cfg_count = 32'd0;
    @(posedge app_clk);
    #1 cfg_enable = 1'b1;
    wait_bytes(12, 200);
    check("ovf before pulse", 32'(overflow_seen), 32'd0);
    @(posedge app_clk);
    #1 bus.app_tx_overflow = 1'b1;
    @(posedge app_clk);
    #1 bus.app_tx_overflow = 1'b0;
    @(negedge app_clk);
    check("ovf set", 32'(overflow_seen), 32'd1);
    repeat (3) @(negedge app_clk);
    check("ovf sticky", 32'(overflow_seen), 32'd1);
    wait_bytes(20, 200);
    check("pkt_sent before reset", pkt_sent, 32'd2);
    @(posedge app_clk);
    #1;
    app_rst = 1'b1;
    cfg_enable = 1'b0;
    @(posedge app_clk);
    #1 app_rst = 1'b0;
    @(negedge app_clk);
    check("rst dvld", 32'(bus.app_tx_dvld), 32'd0);
    check("rst eof", 32'(bus.app_tx_eof), 32'd0);
    check("rst pkt_sent", pkt_sent, 32'd0);
    check("rst ovf", 32'(overflow_seen), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    repeat (2) @(posedge app_clk);
    run("restart", 16'd8, 16'd0, 32'd1, 8, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gbe_app_pktgen.md
Name: gbe_app_pktgen

Overview:
- Test-traffic generator on the application TX side of the UDP GbE core, in the app_clk domain.
- Drives the core's app_tx_* byte interface with numbered UDP payloads of configurable length and inter-packet gap, honouring app_tx_afull.
- Used by test gateware for link, throughput and packet-loss checks. A receiver can detect loss from the 32-bit sequence number at the head of each payload.

Parameters:
- MIN_LEN, 4, minimum payload bytes. Shorter cfg_length is raised to this.
- MAX_LEN, 1472, maximum payload bytes. Longer cfg_length is clamped to this.

Ports:
- app_clk  in  1  sole clock.
- app_rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  level. 1 = run, 0 = stop at the next packet boundary.
- cfg_length  in  16  payload bytes per packet.
- cfg_gap  in  16  idle cycles between packets.
- cfg_count  in  32  packets per run. 0 = unlimited.
- cfg_destip  in  32  destination IP.
- cfg_destport  in  16  destination UDP port.
- app_tx_data  out  8  payload byte.
- app_tx_dvld  out  1  byte valid.
- app_tx_eof  out  1  last byte of packet, asserted only together with dvld.
- app_tx_destip  out  32  latched destination IP.
- app_tx_destport  out  16  latched destination port.
- app_tx_afull  in  1  core TX FIFO almost full.
- app_tx_overflow  in  1  core TX FIFO overflow.
- pkt_sent  out  32  packets completed this run.
- busy  out  1  run in progress.
- done  out  1  cfg_count reached.
- overflow_seen  out  1  sticky overflow flag.

Behaviour:
- Reset state: all outputs registered. On app_rst every output is 0 the following cycle and the FSM goes to IDLE, including mid-packet (the packet is left truncated; the core discards it on its own app_tx_rst).
- FSM states: IDLE, LOAD, SEND, GAP, DONE.
- IDLE: dvld=eof=0, busy=0. cfg_enable=1 -> LOAD.
- LOAD (1 cycle):
  - Latch the effective length: clamp(cfg_length, MIN_LEN, MAX_LEN), 16-bit compare.
  - Latch gap, count, destip and destport.
  - Clear seq, byte_idx, pkt_sent and overflow_seen.
  - busy=1. -> SEND.
  - cfg_* changes after LOAD have no effect until the next run.
- SEND:
  - In any cycle where app_tx_afull is sampled 0, the next cycle presents one byte with dvld=1.
  - afull=1 -> dvld=0 next cycle. Pause latency is 1 cycle; no byte is skipped or duplicated.
  - Byte content: byte_idx 0..3 = seq[31:24], seq[23:16], seq[15:8], seq[7:0] (big-endian). byte_idx >= 4 = byte_idx[7:0].
  - app_tx_eof=1 with the byte where byte_idx = len-1.
  - At eof: pkt_sent++ and seq++ (both wrap modulo 2^32), byte_idx=0.
- After eof, in priority order:
  - count!=0 and pkt_sent (post-increment) == count -> DONE.
  - cfg_enable=0 -> IDLE.
  - gap==0 -> stay in SEND (back-to-back; the next byte may follow eof in the very next cycle).
  - else -> GAP.
- GAP:
  - Exactly `gap` cycles with dvld=0 between the eof cycle and the first byte of the next packet, when afull stays low.
  - afull asserted during or after GAP only adds delay.
  - cfg_enable=0 during GAP -> IDLE immediately.
- cfg_enable=0 mid-packet: the current packet completes fully with eof, then IDLE. Packets are never truncated except by reset.
- DONE: dvld=0, busy=0, done=1, pkt_sent held. cfg_enable=0 -> IDLE, done=0.
- app_tx_destip/destport: stable from LOAD through the end of the run; they never change inside a packet.
- overflow_seen: set on any cycle with app_tx_overflow=1 while busy. Cleared only by LOAD or reset. The generator does not retransmit.
- Simultaneous afull=1 on the eof-producing edge: that byte is withheld and eof moves with it. The eof cycle is therefore always a dvld cycle.

Test Plan:
1. Basic run: len=8, gap=0, count=2, afull=0. Data must be 00 00 00 00 04 05 06 07 (eof), then immediately 00 00 00 01 04 05 06 07 (eof). Expect 16 consecutive dvld cycles, then pkt_sent=2, done=1, busy=0.
2. Backpressure: len=64; hold afull=1 for 5 cycles starting at byte 20. Expect dvld low for 5 cycles starting 1 cycle later, a resume at byte 20/21 with no gap or duplicate in the byte_idx pattern, and exactly 64 dvld cycles in total.
3. Clamping: cfg_length=2 gives 4-byte packets (seq only, eof on byte 3). cfg_length=2000 gives 1472-byte packets with eof on byte 1471; byte 1471 = 0xBF.
4. Gap: len=16, gap=3, count=3, afull=0. Expect exactly 3 non-dvld cycles between each eof and the next first byte; seq = 0, 1, 2.
5. Stop mid-packet: count=0, len=64; drop cfg_enable at byte 10. The packet still ends with eof at byte 63, then IDLE with busy=0, done=0, and no further dvld.
6. Reset and overflow: pulse app_tx_overflow for 1 cycle mid-run, and check overflow_seen=1 sticky. Then assert app_rst mid-packet: the next cycle dvld=eof=0, pkt_sent=0, overflow_seen=0, busy=0. Re-enabling restarts at seq 0.
